// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time under contention.
// Grant, owner and busy are all registered; req never reaches an output combinationally.
module rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy
);

  // state | meaning
  // IDLE  | no grant outstanding, gnt = 0000
  // GRANT | exactly one gnt bit set, owner holds the datapath

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    last, last_nxt;
  logic [1:0]    owner_nxt;
  logic [3:0]    gnt_nxt;
  logic          busy_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;

  logic [3:0]    search_req;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          found;
  logic          new_grant;

  // While granting, the owner is masked so a forced handoff never re-picks it.
  always_comb begin
    search_req = req;
    if (state == GRANT) search_req[owner] = 1'b0;
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && search_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    busy_nxt  = busy;
    new_grant = 1'b0;

    case (state)
      IDLE: begin
        if (found) new_grant = 1'b1;
      end
      GRANT: begin
        if (!req[owner]) begin
          if (found) begin
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt < HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end else if (found) begin
          new_grant = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
        hold_nxt  = '0;
      end
    endcase

    // Any fresh grant, even back to the same index, restarts the hold window.
    if (new_grant) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << winner;
      owner_nxt = winner;
      last_nxt  = winner;
      hold_nxt  = CW'(1);
      busy_nxt  = 1'b1;
    end
  end

  // last resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      owner    <= 2'd0;
      busy     <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD SHALL be: MAX_HOLD, default 4, maximum consecutive grant cycles while contended (legal range 1..15).
REQ-002 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port SHALL be: clk  input  1  rising-edge clock for all state.
REQ-004 Port SHALL be: reset  input  1  asynchronous active-low reset (reset=0 asserts).
REQ-005 Port SHALL be: req  input  4  request per requester; bit i = requester i wants the shared datapath.
REQ-006 Port SHALL be: gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 Port SHALL be: owner  output  2  index of the current or most recent grantee.
REQ-008 Port SHALL be: busy  output  1  1 when any gnt bit is set.

Function
REQ-009 All outputs SHALL be driven from flops; no combinational path SHALL exist from req to any output.
REQ-010 The state machine SHALL have two states, IDLE (gnt=0000) and GRANT (exactly one gnt bit set).
REQ-011 Internal state SHALL be: a last-winner pointer (2 bits) and a hold counter of width clog2(MAX_HOLD+1).
REQ-012 Arbitration SHALL search req from index (last+1) mod 4 upward with wrap to 0 and select the first set bit.
REQ-013 IDLE: at a rising edge with req!=0, the block SHALL grant the search winner, set last=owner=winner, load hold counter=1 and enter GRANT.
REQ-014 IDLE: at a rising edge with req=0, the block SHALL stay in IDLE with gnt=0000 and owner unchanged.
REQ-015 Grant latency SHALL be exactly one cycle: req sampled at edge N gives gnt valid after edge N.
REQ-016 GRANT, owner's req=0 at an edge: if another req bit is set, the block SHALL grant the search winner at that same edge (no idle gap); otherwise it SHALL enter IDLE.
REQ-017 GRANT, owner's req=1, no other req set: owner SHALL keep the grant and the counter SHALL saturate at MAX_HOLD.
REQ-018 GRANT, owner's req=1, counter<MAX_HOLD: owner SHALL keep the grant and the counter SHALL increment by 1.
REQ-019 GRANT, owner's req=1, counter=MAX_HOLD, another req set: the grant SHALL move to the search winner (which excludes the owner) and the counter SHALL reload to 1.
REQ-020 Every new grant, including a re-grant to the same index after IDLE, SHALL update last and reload the counter to 1.
REQ-021 Requests SHALL NOT be latched: a req bit deasserted before it wins SHALL be forgotten.
REQ-022 With MAX_HOLD=1, a contended grant SHALL rotate every cycle.
REQ-023 busy SHALL equal the OR of gnt at all times.

Reset
REQ-024 reset=0 SHALL immediately and asynchronously force gnt=0000, busy=0, owner=00, counter=0, state=IDLE and last=3, so requester 0 has first priority.
REQ-025 Reset asserted mid-grant SHALL drop the grant within the same cycle, without waiting for a clock edge.
REQ-026 Reset deassertion SHALL take effect at the first rising edge at which reset=1, with arbitration per REQ-013.

Verification
REQ-027 Reset: reset=0 with req=1111 -> gnt=0000, busy=0, owner=00; release reset -> at the first edge gnt=0001, owner=00.
REQ-028 Contention: MAX_HOLD=4, req=1111 held -> gnt=0001 x4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001.
REQ-029 Solo hold: req=0100 held for 10 cycles -> gnt=0100 for all 10 cycles, counter stays at 4, busy=1.
REQ-030 Handoff: owner 0 drops req in its 2nd grant cycle while req[1]=1 -> gnt=0010 at the next edge, with no 0000 cycle.
REQ-031 Reset mid-grant: gnt=0100, pull reset=0 between edges -> gnt=0000 immediately; release with req=0101 -> gnt=0001.
REQ-032 Idle and wrap: req drops to 0000 -> gnt=0000, busy=0 at the next edge; then req=1001 with last=3 -> gnt=0001.
